// File: rtl/alu_regfile_pkg.sv
// -----------------------------------------------------------------------------
// alu_regfile_pkg
// Shared definitions for the alu_regfile datapath slice:
//   - DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and bank address width
//   - alu_op_e                        : 3-bit ALU opcode encoding (OP_ADD..OP_SHR)
// -----------------------------------------------------------------------------
package alu_regfile_pkg;

    localparam int DEFAULT_DATA_W = 4;
    localparam int DEFAULT_ADDR_W = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_regfile_bank.sv
// -----------------------------------------------------------------------------
// regfile_bank
// Register bank of 2**ADDR_W entries of DATA_W bits, one synchronous write
// port and three combinational read ports (debug read plus two ALU operands).
// Ports:
//   clk, rst            : clock, synchronous active-high reset (clears all entries)
//   wr_en/wr_addr/wr_data : write port, takes effect on the rising edge
//   rd_addr   -> rd_data   : debug/output read port
//   op_addr_1 -> op_data_1 : operand A read port
//   op_addr_2 -> op_data_2 : operand B read port
// Reset has priority over a write in the same cycle.
// -----------------------------------------------------------------------------
module regfile_bank
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] op_addr_1,
    output logic [DATA_W-1:0] op_data_1,
    input  logic [ADDR_W-1:0] op_addr_2,
    output logic [DATA_W-1:0] op_data_2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Bank storage: clear on reset, otherwise single-entry write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-edge contents, so an ALU capture coinciding with a
    // write to its operand uses the old value.
    assign rd_data   = mem_r[rd_addr];
    assign op_data_1 = mem_r[op_addr_1];
    assign op_data_2 = mem_r[op_addr_2];

endmodule

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// Datapath core: register bank feeding a registered ALU.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data  : bank write port
//   rd_addr -> rd_data       : combinational debug read of the bank
//   op_addr_1, op_addr_2     : bank entries used as operands A and B
//   alu_en, opcode           : capture ALU result of opcode on this edge
//   alu_out                  : registered ALU result (holds while alu_en low)
//   alu_valid                : high for the cycle after alu_en was sampled high
//   carry, zero              : registered flags, present only when the
//                              ALU_FLAGS_EN macro is defined
// -----------------------------------------------------------------------------
module alu_regfile
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] op_addr_1,
    input  logic [ADDR_W-1:0] op_addr_2,
    input  logic              alu_en,
    input  logic [2:0]        opcode,
    output logic [DATA_W-1:0] alu_out,
    output logic              alu_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic              carry,
    output logic              zero
`endif
);

    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    logic [DATA_W-1:0] result_s;
    alu_op_e           op_s;
    logic [DATA_W-1:0] alu_out_r;
    logic              alu_valid_r;

    regfile_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .op_addr_1 (op_addr_1),
        .op_data_1 (op_a_s),
        .op_addr_2 (op_addr_2),
        .op_data_2 (op_b_s)
    );

    assign op_s = alu_op_e'(opcode);

    // ALU result: all ops truncated to DATA_W.
    always_comb begin
        result_s = '0;
        case (op_s)
            OP_ADD:  result_s = op_a_s + op_b_s;
            OP_SUB:  result_s = op_a_s - op_b_s;
            OP_AND:  result_s = op_a_s & op_b_s;
            OP_OR:   result_s = op_a_s | op_b_s;
            OP_XOR:  result_s = op_a_s ^ op_b_s;
            OP_NOT:  result_s = ~op_a_s;
            OP_SHL:  result_s = {op_a_s[DATA_W-2:0], 1'b0};
            OP_SHR:  result_s = {1'b0, op_a_s[DATA_W-1:1]};
            default: result_s = '0;
        endcase
    end

    // Result and valid registers; result holds while alu_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_r   <= '0;
            alu_valid_r <= 1'b0;
        end else if (alu_en) begin
            alu_out_r   <= result_s;
            alu_valid_r <= 1'b1;
        end else begin
            alu_out_r   <= alu_out_r;
            alu_valid_r <= 1'b0;
        end
    end

    assign alu_out   = alu_out_r;
    assign alu_valid = alu_valid_r;

`ifdef ALU_FLAGS_EN
    logic [DATA_W:0] sum_s;
    logic            carry_s;
    logic            zero_s;
    logic            carry_r;
    logic            zero_r;

    // Widened add so the carry-out is bit DATA_W.
    assign sum_s = {1'b0, op_a_s} + {1'b0, op_b_s};

    // Carry: add carry-out, subtract borrow, shifted-out bit; 0 for logic ops.
    always_comb begin
        carry_s = 1'b0;
        case (op_s)
            OP_ADD:  carry_s = sum_s[DATA_W];
            OP_SUB:  carry_s = (op_a_s < op_b_s);
            OP_SHL:  carry_s = op_a_s[DATA_W-1];
            OP_SHR:  carry_s = op_a_s[0];
            default: carry_s = 1'b0;
        endcase
    end

    assign zero_s = (result_s == '0);

    // Flag registers, updated alongside alu_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
        end else if (alu_en) begin
            carry_r <= carry_s;
            zero_r  <= zero_s;
        end else begin
            carry_r <= carry_r;
            zero_r  <= zero_r;
        end
    end

    assign carry = carry_r;
    assign zero  = zero_r;
`endif

endmodule

// File: tb/tb_alu_regfile.sv
// -----------------------------------------------------------------------------
// tb_alu_regfile
// Self-checking bench for alu_regfile: directed scenarios plus randomized
// traffic compared against a behavioural model (integer arithmetic on an
// array bank). Flag checks are compiled only when ALU_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_regfile;

    localparam int DW = 4;
    localparam int AW = 2;
    localparam int NE = 1 << AW;
    localparam int MD = 1 << DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] op_addr_1 = '0;
    logic [AW-1:0] op_addr_2 = '0;
    logic          alu_en = 1'b0;
    logic [2:0]    opcode = 3'd0;
    logic [DW-1:0] alu_out;
    logic          alu_valid;
`ifdef ALU_FLAGS_EN
    logic          carry;
    logic          zero;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    int mb [NE];
    int m_out = 0, m_valid = 0, m_c = 0, m_z = 0;

    alu_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .op_addr_1 (op_addr_1),
        .op_addr_2 (op_addr_2),
        .alu_en    (alu_en),
        .opcode    (opcode),
        .alu_out   (alu_out),
        .alu_valid (alu_valid)
`ifdef ALU_FLAGS_EN
        ,
        .carry     (carry),
        .zero      (zero)
`endif
    );

    always #5 clk = ~clk;

    // Arithmetic reference for each opcode, from plain integer math.
    function automatic void alu_ref(input int op, input int a, input int b,
                                    output int res, output int c);
        res = 0;
        c   = 0;
        case (op)
            0: begin res = (a + b) % MD; c = ((a + b) >= MD) ? 1 : 0; end
            1: begin res = (a - b + MD) % MD; c = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = MD - 1 - a;
            6: begin res = (a * 2) % MD; c = (a >= MD / 2) ? 1 : 0; end
            7: begin res = a / 2; c = a % 2; end
            default: res = 0;
        endcase
    endfunction

    // Advance the model using the currently driven inputs, then clock the DUT.
    task automatic tick();
        int r, c;
        if (rst) begin
            for (int i = 0; i < NE; i++) mb[i] = 0;
            m_out = 0; m_valid = 0; m_c = 0; m_z = 0;
        end else begin
            if (alu_en) begin
                alu_ref(int'(opcode), mb[op_addr_1], mb[op_addr_2], r, c);
                m_out = r; m_c = c; m_z = (r == 0) ? 1 : 0; m_valid = 1;
            end else begin
                m_valid = 0;
            end
            if (wr_en) mb[wr_addr] = int'(wr_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d; alu_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        opcode = op; op_addr_1 = a1; op_addr_2 = a2; alu_en = 1'b1;
        tick();
        alu_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NE; i++) begin
            rd_addr = AW'(i);
            #1;
            total_cnt++;
            if (rd_data !== '0) $display("FAIL reset_rd[%0d] got %h exp 0", i, rd_data);
            else pass_cnt++;
        end
        total_cnt++;
        if (alu_out !== '0) $display("FAIL reset_alu_out got %h exp 0", alu_out); else pass_cnt++;
        total_cnt++;
        if (alu_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", alu_valid); else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({carry, zero} !== 2'b00) $display("FAIL reset_flags got %b%b exp 00", carry, zero); else pass_cnt++;
`endif
    endtask

    task automatic test_add_sub();
        write_reg(2'd0, 4'h7);
        write_reg(2'd1, 4'h3);
        do_op(3'b000, 2'd0, 2'd1);
        total_cnt++;
        if (alu_out !== 4'hA || alu_valid !== 1'b1)
            $display("FAIL add_basic got %h/%b exp a/1", alu_out, alu_valid);
        else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({carry, zero} !== 2'b00) $display("FAIL add_basic_flags got %b%b exp 00", carry, zero); else pass_cnt++;
`endif
        // alu_en low: result holds, valid drops
        tick();
        total_cnt++;
        if (alu_out !== 4'hA || alu_valid !== 1'b0)
            $display("FAIL hold got %h/%b exp a/0", alu_out, alu_valid);
        else pass_cnt++;

        write_reg(2'd0, 4'hF);
        write_reg(2'd1, 4'h1);
        do_op(3'b000, 2'd0, 2'd1);
        total_cnt++;
        if (alu_out !== 4'h0) $display("FAIL add_wrap got %h exp 0", alu_out); else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({carry, zero} !== 2'b11) $display("FAIL add_wrap_flags got %b%b exp 11", carry, zero); else pass_cnt++;
`endif
        do_op(3'b001, 2'd1, 2'd0);
        total_cnt++;
        if (alu_out !== 4'h2) $display("FAIL sub_borrow got %h exp 2", alu_out); else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({carry, zero} !== 2'b10) $display("FAIL sub_borrow_flags got %b%b exp 10", carry, zero); else pass_cnt++;
`endif
        // Same operand on both sides
        do_op(3'b001, 2'd0, 2'd0);
        total_cnt++;
        if (alu_out !== 4'h0) $display("FAIL sub_self got %h exp 0", alu_out); else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({carry, zero} !== 2'b01) $display("FAIL sub_self_flags got %b%b exp 01", carry, zero); else pass_cnt++;
`endif
    endtask

    task automatic test_shift_not();
        write_reg(2'd2, 4'b1001);
        do_op(3'b110, 2'd2, 2'd0);
        total_cnt++;
        if (alu_out !== 4'b0010) $display("FAIL shl got %b exp 0010", alu_out); else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if (carry !== 1'b1) $display("FAIL shl_carry got %b exp 1", carry); else pass_cnt++;
`endif
        do_op(3'b111, 2'd2, 2'd0);
        total_cnt++;
        if (alu_out !== 4'b0100) $display("FAIL shr got %b exp 0100", alu_out); else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if (carry !== 1'b1) $display("FAIL shr_carry got %b exp 1", carry); else pass_cnt++;
`endif
        do_op(3'b101, 2'd2, 2'd0);
        total_cnt++;
        if (alu_out !== 4'b0110) $display("FAIL not got %b exp 0110", alu_out); else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({carry, zero} !== 2'b00) $display("FAIL not_flags got %b%b exp 00", carry, zero); else pass_cnt++;
`endif
    endtask

    task automatic test_write_collision();
        write_reg(2'd0, 4'h2);
        write_reg(2'd1, 4'h1);
        // Write and ALU capture on the same edge: old operand value used
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h5;
        do_op(3'b000, 2'd0, 2'd1);
        wr_en = 1'b0;
        total_cnt++;
        if (alu_out !== 4'h3) $display("FAIL collide_old got %h exp 3", alu_out); else pass_cnt++;
        do_op(3'b000, 2'd0, 2'd1);
        total_cnt++;
        if (alu_out !== 4'h6) $display("FAIL collide_new got %h exp 6", alu_out); else pass_cnt++;
    endtask

    task automatic test_reset_override();
        write_reg(2'd3, 4'hC);
        do_op(3'b011, 2'd3, 2'd3);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'h9;
        alu_en = 1'b1; opcode = 3'b011; op_addr_1 = 2'd3; op_addr_2 = 2'd3;
        tick();
        rst = 1'b0; wr_en = 1'b0; alu_en = 1'b0;
        total_cnt++;
        if (alu_out !== 4'h0 || alu_valid !== 1'b0)
            $display("FAIL rst_override_alu got %h/%b exp 0/0", alu_out, alu_valid);
        else pass_cnt++;
        for (int i = 0; i < NE; i++) begin
            rd_addr = AW'(i);
            #1;
            total_cnt++;
            if (rd_data !== '0) $display("FAIL rst_override_rd[%0d] got %h exp 0", i, rd_data);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NE; i++) write_reg(AW'(i), DW'($urandom));
        for (int k = 0; k < 8; k++) begin
            opcode = 3'($urandom); op_addr_1 = AW'($urandom); op_addr_2 = AW'($urandom);
            alu_en = 1'b1;
            tick();
            total_cnt++;
            if (alu_valid !== 1'b1 || alu_out !== DW'(m_out))
                $display("FAIL b2b[%0d] got %h/%b exp %h/1", k, alu_out, alu_valid, DW'(m_out));
            else pass_cnt++;
        end
        alu_en = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 31) == 0);
            wr_en     = 1'($urandom);
            wr_addr   = AW'($urandom);
            wr_data   = DW'($urandom);
            op_addr_1 = AW'($urandom);
            op_addr_2 = AW'($urandom);
            opcode    = 3'($urandom);
            alu_en    = 1'($urandom);
            tick();
            rst = 1'b0; wr_en = 1'b0; alu_en = 1'b0;
            rd_addr = AW'($urandom);
            #1;
            total_cnt++;
            if (alu_out !== DW'(m_out) || alu_valid !== 1'(m_valid) || rd_data !== DW'(mb[rd_addr]))
                $display("FAIL rand[%0d] got out=%h v=%b rd=%h exp out=%h v=%0d rd=%h",
                         k, alu_out, alu_valid, rd_data, DW'(m_out), m_valid, DW'(mb[rd_addr]));
            else pass_cnt++;
`ifdef ALU_FLAGS_EN
            total_cnt++;
            if (carry !== 1'(m_c) || zero !== 1'(m_z))
                $display("FAIL rand_flags[%0d] got %b%b exp %0d%0d", k, carry, zero, m_c, m_z);
            else pass_cnt++;
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < NE; i++) mb[i] = 0;
        test_reset();
        test_add_sub();
        test_shift_not();
        test_write_collision();
        test_reset_override();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
